// File: rtl/pc_fetch_if.sv
// Fetch-side interface of pc_fetch: PC load controls, fetch handshake,
// memory read channel and the registered result outputs.
interface pc_fetch_if;
  logic        start;
  logic        ld_pc;
  logic [1:0]  pcmux_sel;
  logic [15:0] bus_in;
  logic [15:0] adder_in;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] pc_out;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;

  modport master (
    output start, ld_pc, pcmux_sel, bus_in, adder_in, mem_ready, mem_rdata,
    input  mem_req, mem_addr, pc_out, ir_out, ir_valid, busy, fetch_err
  );

  modport slave (
    input  start, ld_pc, pcmux_sel, bus_in, adder_in, mem_ready, mem_rdata,
    output mem_req, mem_addr, pc_out, ir_out, ir_valid, busy, fetch_err
  );
endinterface

// File: rtl/pc_fetch.sv
// LC-3b program counter and instruction-fetch sequencer. Two states:
// IDLE accepts PC loads and fetch starts, WAIT holds the memory request
// until mem_ready or the timeout counter expires. All outputs registered.
module pc_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h3000,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  pc_fetch_if.slave   bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d, ir_q, ir_d, pc_sel;
  logic        req_q, req_d, irv_q, irv_d, busy_q, busy_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // PC mux; loaded values are forced to a word boundary
  always_comb begin
    pc_sel = pc_q;
    unique case (bus.pcmux_sel)
      2'b00: pc_sel = pc_q + 16'd2;
      2'b01: pc_sel = {bus.bus_in[15:1], 1'b0};
      2'b10: pc_sel = {bus.adder_in[15:1], 1'b0};
      2'b11: pc_sel = pc_q;
    endcase
  end

  // next-state and next-output logic; pulses default low each cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    req_d   = req_q;
    irv_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ld_pc) pc_d = pc_sel;
        if (bus.start) begin
          // fetch uses the PC as updated by a same-edge load
          addr_d  = bus.ld_pc ? pc_sel : pc_q;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          irv_d   = 1'b1;
          pc_d    = addr_q + 16'd2;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset; reset abandons any fetch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 16'd0;
      ir_q    <= 16'd0;
      req_q   <= 1'b0;
      irv_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      irv_q   <= irv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.mem_addr  = addr_q;
  assign bus.ir_out    = ir_q;
  assign bus.mem_req   = req_q;
  assign bus.ir_valid  = irv_q;
  assign bus.busy      = busy_q;
  assign bus.fetch_err = err_q;
endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program-counter register and instruction-fetch sequencer for the LC-3b datapath. Holds the architectural PC and selects its next value (PC+2, bus, address adder). Runs a request/ready memory fetch into the instruction register. pc_out feeds the PC tri-state bus driver directly downstream, which gates it onto the shared bus.

Parameters:
RESET_PC, 16'h3000, PC value after reset (bit 0 must be 0)
MEM_TIMEOUT, 15, WAIT cycles without mem_ready before a fetch is aborted (1..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  begin instruction fetch at current PC (sampled in IDLE only)
ld_pc  in  1  load PC from pcmux selection (sampled in IDLE only)
pcmux_sel  in  2  00 PC+2, 01 bus_in, 10 adder_in, 11 hold
bus_in  in  16  value from shared bus
adder_in  in  16  value from address adder
mem_ready  in  1  memory read data valid
mem_rdata  in  16  memory read data
mem_req  out  1  read request, held until accepted or timeout
mem_addr  out  16  fetch address (word aligned)
pc_out  out  16  current PC, to PC bus driver input
ir_out  out  16  instruction register
ir_valid  out  1  one-cycle pulse: ir_out newly loaded
busy  out  1  fetch in progress
fetch_err  out  1  one-cycle pulse: fetch timed out

Behaviour:
- Single clock, synchronous active-low reset, all outputs registered.
- Reset (reset_n=0 at an edge, including mid-fetch): pc_out=RESET_PC, mem_addr=0, mem_req=0, ir_out=0, ir_valid=0, busy=0, fetch_err=0, timeout counter=0, state=IDLE. Any outstanding request is abandoned.
- States: IDLE, WAIT.
- IDLE, ld_pc=1: pc_out <= selected value with bit 0 forced to 0.
  - PC+2 is modulo 2^16 (16'hFFFE -> 16'h0000).
  - pcmux_sel=11 leaves PC unchanged.
- IDLE, start=1: mem_addr <= PC value after any same-edge ld_pc update; mem_req <= 1, busy <= 1, counter <= 0, go to WAIT.
  - ld_pc and start on the same edge: the PC is loaded and the fetch uses the new PC.
- WAIT, mem_ready=1 (takes priority over timeout on the same edge):
  - ir_out <= mem_rdata, ir_valid <= 1 for exactly one cycle.
  - pc_out <= mem_addr+2 (wraps).
  - mem_req <= 0, busy <= 0, go to IDLE.
- WAIT, mem_ready=0: counter increments. When counter reaches MEM_TIMEOUT-1 without ready:
  - fetch_err <= 1 for one cycle, mem_req <= 0, busy <= 0, go to IDLE.
  - pc_out and ir_out unchanged.
- WAIT: start and ld_pc are ignored, with no queuing. mem_addr is stable while mem_req=1.
- IDLE: mem_ready is ignored.
- Latency: start edge N, mem_ready high at edge N+1 -> ir_valid high after edge N+1 (fetch-to-valid 2 cycles minimum).
- ir_valid and fetch_err are never both high.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> pc_out=3000, all other outputs 0. Release and idle 5 cycles -> no change.
- Normal fetch:
  - start in IDLE -> mem_req=1, mem_addr=3000, busy=1.
  - mem_ready=1 with rdata=1234 after 3 WAIT cycles -> ir_out=1234, ir_valid pulses 1 cycle, pc_out=3002, mem_req=0.
- PC loads:
  - ld_pc with sel=01, bus_in=4567 -> pc_out=4566.
  - sel=10, adder_in=FFFE, then sel=00 -> pc_out=FFFE, then 0000.
  - sel=11 -> unchanged.
- Simultaneous and ignored events:
  - ld_pc (sel=01, bus_in=5000) and start on same edge -> mem_addr=5000.
  - start/ld_pc during WAIT -> no effect.
  - mem_ready pulse in IDLE -> ir_valid stays 0.
- Timeout: start with mem_ready held 0 -> fetch_err pulses exactly MEM_TIMEOUT=15 cycles after busy rises. pc_out and ir_out unchanged, mem_req=0.
- Reset mid-fetch: reset_n=0 during WAIT -> next edge mem_req=0, busy=0, pc_out=3000. mem_ready arriving afterwards does not load ir_out.
